// File: rtl/alarm_clock_pkg.sv
// Shared types and helpers for the multi-alarm clock: BCD HH:MM struct, alarm FSM states,
// keypad/ASCII constants and HH:MM validation and minute arithmetic.
package alarm_clock_pkg;

   localparam logic [3:0] KEY_NONE   = 4'd10;
   localparam logic [7:0] ASCII_ZERO = 8'h30;

   typedef struct packed {
      logic [3:0] ms_hr;
      logic [3:0] ls_hr;
      logic [3:0] ms_min;
      logic [3:0] ls_min;
   } hhmm_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RINGING,
      ST_SNOOZED
   } alarm_state_e;

   // Digits always come from the keypad (0-9), so only the tens digits need range checks.
   function automatic logic hhmm_valid(input hhmm_t t);
      logic w_hr_ok;
      logic w_min_ok;
      w_hr_ok  = (t.ms_hr < 4'd2) || ((t.ms_hr == 4'd2) && (t.ls_hr <= 4'd3));
      w_min_ok = (t.ms_min <= 4'd5);
      return w_hr_ok && w_min_ok;
   endfunction

   function automatic hhmm_t hhmm_add_min(input hhmm_t t, input int m);
      int    v;
      hhmm_t r;
      v = ((int'(t.ms_hr) * 10 + int'(t.ls_hr)) * 60
           + int'(t.ms_min) * 10 + int'(t.ls_min) + m) % 1440;
      r.ms_hr  = 4'((v / 60) / 10);
      r.ls_hr  = 4'((v / 60) % 10);
      r.ms_min = 4'((v % 60) / 10);
      r.ls_min = 4'((v % 60) % 10);
      return r;
   endfunction

endpackage

// File: rtl/hhmm_counter.sv
// BCD HH:MM register with parallel load and one-minute increment, wrapping 23:59 -> 00:00.
// Load takes priority over increment in the same cycle.
module hhmm_counter
   import alarm_clock_pkg::*;
(
   input  logic  i_clock,
   input  logic  i_reset,
   input  logic  i_load,
   input  hhmm_t i_load_val,
   input  logic  i_inc,
   output hhmm_t o_hhmm
);

   hhmm_t r_hhmm;
   hhmm_t w_inc_val;

   always_comb begin
      w_inc_val = r_hhmm;
      if (r_hhmm.ls_min != 4'd9) begin
         w_inc_val.ls_min = r_hhmm.ls_min + 4'd1;
      end else begin
         w_inc_val.ls_min = 4'd0;
         if (r_hhmm.ms_min != 4'd5) begin
            w_inc_val.ms_min = r_hhmm.ms_min + 4'd1;
         end else begin
            w_inc_val.ms_min = 4'd0;
            if ((r_hhmm.ms_hr == 4'd2) && (r_hhmm.ls_hr == 4'd3)) begin
               w_inc_val.ms_hr = 4'd0;
               w_inc_val.ls_hr = 4'd0;
            end else if (r_hhmm.ls_hr == 4'd9) begin
               w_inc_val.ms_hr = r_hhmm.ms_hr + 4'd1;
               w_inc_val.ls_hr = 4'd0;
            end else begin
               w_inc_val.ls_hr = r_hhmm.ls_hr + 4'd1;
            end
         end
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_hhmm <= '0;
      end else if (i_load) begin
         r_hhmm <= i_load_val;
      end else if (i_inc) begin
         r_hhmm <= w_inc_val;
      end
   end

   assign o_hhmm = r_hhmm;

endmodule

// File: rtl/multi_alarm_clock.sv
// 24-hour HH:MM clock with keypad entry, NUM_ALARMS alarm slots, snooze and ring timeout.
// All outputs are registered; alarms assert one edge after the time register shows the match.
module multi_alarm_clock
   import alarm_clock_pkg::*;
#(
   parameter  int NUM_ALARMS      = 4,
   parameter  int CLK_PER_SEC     = 256,
   parameter  int SNOOZE_MIN      = 5,
   parameter  int ALARM_TIMEOUT_S = 10,
   localparam int SEL_W           = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
)(
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_fastwatch,
   input  logic [3:0]            i_key,
   input  logic                  i_time_button,
   input  logic                  i_alarm_button,
   input  logic [SEL_W-1:0]      i_alarm_sel,
   input  logic [NUM_ALARMS-1:0] i_alarm_en,
   input  logic                  i_snooze,
   input  logic                  i_stop_alarm,
   output logic                  o_alarm_sound,
   output logic [NUM_ALARMS-1:0] o_alarm_active,
   output logic                  o_entry_err,
   output logic [7:0]            o_ms_hour,
   output logic [7:0]            o_ls_hour,
   output logic [7:0]            o_ms_minute,
   output logic [7:0]            o_ls_minute
);

   localparam int PRE_W = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
   localparam int TO_W  = $clog2(ALARM_TIMEOUT_S + 1);

   logic [PRE_W-1:0]      r_presc;
   logic [5:0]            r_sec;
   logic                  r_time_chg;
   logic [3:0]            r_key_q;
   hhmm_t                 r_buf;
   logic                  r_entry;
   logic                  r_entry_err;
   hhmm_t                 r_disp;
   hhmm_t                 r_slot [NUM_ALARMS];
   alarm_state_e          r_state;
   alarm_state_e          w_state_nxt;
   logic [NUM_ALARMS-1:0] r_active;
   logic [NUM_ALARMS-1:0] w_active_nxt;
   logic [NUM_ALARMS-1:0] w_match;
   hhmm_t                 r_target;
   hhmm_t                 w_target_nxt;
   logic [TO_W-1:0]       r_to_cnt;
   logic [TO_W-1:0]       w_to_cnt_nxt;
   logic                  r_alarm_sound;
   hhmm_t                 w_time;
   logic                  w_press;
   logic                  w_sec_tick;
   logic                  w_min_tick;
   logic                  w_buf_ok;
   logic                  w_any_btn;
   logic                  w_time_load;
   logic                  w_alarm_load;
   logic                  w_tgt_hit;

   // A held key is only seen once: it must follow a no-key cycle.
   assign w_press      = (i_key <= 4'd9) && (r_key_q > 4'd9);
   assign w_sec_tick   = (r_presc == PRE_W'(CLK_PER_SEC - 1));
   assign w_min_tick   = w_sec_tick && (i_fastwatch || (r_sec == 6'd59));
   assign w_buf_ok     = hhmm_valid(r_buf);
   assign w_any_btn    = i_time_button || i_alarm_button;
   assign w_time_load  = i_time_button && w_buf_ok;
   assign w_alarm_load = !i_time_button && i_alarm_button && w_buf_ok;

   hhmm_counter u_time (
      .i_clock    (i_clock),
      .i_reset    (i_reset),
      .i_load     (w_time_load),
      .i_load_val (r_buf),
      .i_inc      (w_min_tick),
      .o_hhmm     (w_time)
   );

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_presc    <= '0;
         r_sec      <= '0;
         r_time_chg <= 1'b0;
      end else begin
         r_time_chg <= w_time_load || w_min_tick;
         if (w_time_load) begin
            r_presc <= '0;
            r_sec   <= '0;
         end else begin
            r_presc <= w_sec_tick ? '0 : r_presc + PRE_W'(1);
            if (i_fastwatch)
               r_sec <= '0;
            else if (w_sec_tick)
               r_sec <= (r_sec == 6'd59) ? 6'd0 : r_sec + 6'd1;
         end
      end
   end

   // A load always restarts the buffer; a digit pressed in the same cycle seeds the new one.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_key_q     <= KEY_NONE;
         r_buf       <= '0;
         r_entry     <= 1'b0;
         r_entry_err <= 1'b0;
         r_disp      <= '0;
      end else begin
         r_key_q     <= i_key;
         r_entry_err <= w_any_btn && !w_buf_ok;
         r_disp      <= r_entry ? r_buf : w_time;
         if (w_any_btn) begin
            r_buf   <= w_press ? hhmm_t'({12'd0, i_key}) : hhmm_t'('0);
            r_entry <= w_press;
         end else if (w_press) begin
            r_buf   <= {r_buf.ls_hr, r_buf.ms_min, r_buf.ls_min, i_key};
            r_entry <= 1'b1;
         end
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         for (int i = 0; i < NUM_ALARMS; i++) r_slot[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_ALARMS; i++)
            if (w_alarm_load && (i_alarm_sel == SEL_W'(i))) r_slot[i] <= r_buf;
      end
   end

   always_comb begin
      w_match = '0;
      for (int i = 0; i < NUM_ALARMS; i++)
         w_match[i] = r_time_chg && i_alarm_en[i] && (r_slot[i] == w_time);
   end

   assign w_tgt_hit = r_time_chg && (w_time == r_target);

   always_comb begin
      w_state_nxt  = r_state;
      w_active_nxt = r_active;
      w_target_nxt = r_target;
      w_to_cnt_nxt = r_to_cnt;
      case (r_state)
         ST_IDLE: begin
            if (|w_match) begin
               w_state_nxt  = ST_RINGING;
               w_active_nxt = w_match;
               w_to_cnt_nxt = '0;
            end
         end
         ST_RINGING: begin
            if (i_stop_alarm) begin
               w_state_nxt  = ST_IDLE;
               w_active_nxt = '0;
            end else if (i_snooze) begin
               w_state_nxt  = ST_SNOOZED;
               w_target_nxt = hhmm_add_min(w_time, SNOOZE_MIN);
            end else begin
               w_active_nxt = r_active | w_match;
               if (w_sec_tick) begin
                  if (r_to_cnt == TO_W'(ALARM_TIMEOUT_S - 1)) begin
                     w_state_nxt  = ST_IDLE;
                     w_active_nxt = '0;
                     w_to_cnt_nxt = '0;
                  end else begin
                     w_to_cnt_nxt = r_to_cnt + TO_W'(1);
                  end
               end
            end
         end
         ST_SNOOZED: begin
            if (i_stop_alarm) begin
               w_state_nxt  = ST_IDLE;
               w_active_nxt = '0;
            end else if ((|w_match) || w_tgt_hit) begin
               w_state_nxt  = ST_RINGING;
               w_active_nxt = r_active | w_match;
               w_to_cnt_nxt = '0;
            end
         end
         default: begin
            w_state_nxt  = ST_IDLE;
            w_active_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state       <= ST_IDLE;
         r_active      <= '0;
         r_target      <= '0;
         r_to_cnt      <= '0;
         r_alarm_sound <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_active      <= w_active_nxt;
         r_target      <= w_target_nxt;
         r_to_cnt      <= w_to_cnt_nxt;
         r_alarm_sound <= (w_state_nxt == ST_RINGING);
      end
   end

   assign o_alarm_sound  = r_alarm_sound;
   assign o_alarm_active = r_active;
   assign o_entry_err    = r_entry_err;
   assign o_ms_hour      = ASCII_ZERO + {4'd0, r_disp.ms_hr};
   assign o_ls_hour      = ASCII_ZERO + {4'd0, r_disp.ls_hr};
   assign o_ms_minute    = ASCII_ZERO + {4'd0, r_disp.ms_min};
   assign o_ls_minute    = ASCII_ZERO + {4'd0, r_disp.ls_min};

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Bench for multi_alarm_clock: directed scenarios plus random keypad/button/snooze traffic,
// checked every cycle against a minute-of-day reference model.
module tb_multi_alarm_clock;

   localparam int NA  = 4;
   localparam int CPS = 256;
   localparam int SN  = 5;
   localparam int TO  = 10;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          fw = 1'b0;
   logic [3:0]    key = 4'd15;
   logic          time_btn = 1'b0;
   logic          alarm_btn = 1'b0;
   logic [1:0]    sel = 2'd0;
   logic [NA-1:0] en = '0;
   logic          snz = 1'b0;
   logic          stp = 1'b0;
   logic          o_sound;
   logic [NA-1:0] o_active;
   logic          o_err;
   logic [7:0]    o_mh, o_lh, o_mm, o_lm;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state: time as minutes since midnight, buffer as a 4-digit decimal.
   int m_presc, m_sec, m_min, m_keyq, m_buf, m_mode, m_act, m_target, m_cnt, m_disp;
   bit m_chg, m_entry, m_err;
   int m_slot [NA];

   multi_alarm_clock #(
      .NUM_ALARMS(NA), .CLK_PER_SEC(CPS), .SNOOZE_MIN(SN), .ALARM_TIMEOUT_S(TO)
   ) dut (
      .i_clock(clk), .i_reset(rst), .i_fastwatch(fw), .i_key(key),
      .i_time_button(time_btn), .i_alarm_button(alarm_btn), .i_alarm_sel(sel),
      .i_alarm_en(en), .i_snooze(snz), .i_stop_alarm(stp),
      .o_alarm_sound(o_sound), .o_alarm_active(o_active), .o_entry_err(o_err),
      .o_ms_hour(o_mh), .o_ls_hour(o_lh), .o_ms_minute(o_mm), .o_ls_minute(o_lm)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ascii4(input int v);
      logic [31:0] r;
      r[31:24] = 8'h30 + 8'((v / 1000) % 10);
      r[23:16] = 8'h30 + 8'((v / 100) % 10);
      r[15:8]  = 8'h30 + 8'((v / 10) % 10);
      r[7:0]   = 8'h30 + 8'(v % 10);
      return r;
   endfunction

   function automatic int min_to_hhmm(input int m);
      return (m / 60) * 100 + (m % 60);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_presc = 0; m_sec = 0; m_min = 0; m_chg = 0; m_keyq = 10; m_buf = 0;
      m_entry = 0; m_mode = 0; m_act = 0; m_target = 0; m_cnt = 0;
      m_disp = 0; m_err = 0;
      for (int i = 0; i < NA; i++) m_slot[i] = 0;
   endtask

   task automatic model_step();
      bit press, stick, mtick, valid, anybtn, tload, aload, tgt;
      int mb, bufmin;
      press  = (key <= 4'd9) && (m_keyq > 9);
      stick  = (m_presc == CPS - 1);
      mtick  = stick && (fw || m_sec == 59);
      valid  = (m_buf / 100 <= 23) && (m_buf % 100 <= 59);
      bufmin = (m_buf / 100) * 60 + (m_buf % 100);
      anybtn = time_btn || alarm_btn;
      tload  = time_btn && valid;
      aload  = !time_btn && alarm_btn && valid;
      mb = 0;
      for (int i = 0; i < NA; i++)
         if (m_chg && en[i] && m_slot[i] == m_min) mb |= (1 << i);
      tgt = m_chg && (m_min == m_target);
      // mode: 0 quiet, 1 ringing, 2 snoozed
      if (m_mode == 0) begin
         if (mb != 0) begin m_mode = 1; m_act = mb; m_cnt = 0; end
      end else if (m_mode == 1) begin
         if (stp) begin m_mode = 0; m_act = 0; end
         else if (snz) begin m_mode = 2; m_target = (m_min + SN) % 1440; end
         else begin
            m_act |= mb;
            if (stick) begin
               m_cnt++;
               if (m_cnt == TO) begin m_mode = 0; m_act = 0; end
            end
         end
      end else begin
         if (stp) begin m_mode = 0; m_act = 0; end
         else if (mb != 0 || tgt) begin m_mode = 1; m_act |= mb; m_cnt = 0; end
      end
      m_err  = anybtn && !valid;
      m_disp = m_entry ? m_buf : min_to_hhmm(m_min);
      m_chg  = tload || mtick;
      if (tload) begin
         m_min = bufmin; m_sec = 0; m_presc = 0;
      end else begin
         m_presc = stick ? 0 : m_presc + 1;
         if (fw) m_sec = 0;
         else if (stick) m_sec = (m_sec + 1) % 60;
         if (mtick) m_min = (m_min + 1) % 1440;
      end
      if (aload) m_slot[sel] = bufmin;
      if (anybtn) begin
         m_buf = press ? int'(key) : 0; m_entry = press;
      end else if (press) begin
         m_buf = (m_buf * 10 + int'(key)) % 10000; m_entry = 1;
      end
      m_keyq = int'(key);
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) model_reset();
         else model_step();
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rst === 1'b0) begin
            check("sound", 32'(o_sound), 32'(m_mode == 1));
            check("active", 32'(o_active), 32'(m_act));
            check("entry_err", 32'(o_err), 32'(m_err));
            check("display", {o_mh, o_lh, o_mm, o_lm}, ascii4(m_disp));
         end
      end
   end

   task automatic press(input int d, input int hold, input int gap);
      key = 4'(d);
      repeat (hold) @(negedge clk);
      key = 4'd15;
      repeat (gap) @(negedge clk);
   endtask

   task automatic enter4(input int v);
      press((v / 1000) % 10, 3, 10);
      press((v / 100) % 10, 3, 10);
      press((v / 10) % 10, 3, 10);
      press(v % 10, 3, 10);
   endtask

   task automatic load(input logic t, input logic a, output logic err);
      time_btn = t; alarm_btn = a;
      @(negedge clk);
      err = o_err;
      time_btn = 1'b0; alarm_btn = 1'b0;
      @(negedge clk);
   endtask

   task automatic pulse_stop();
      stp = 1'b1; @(negedge clk); stp = 1'b0; @(negedge clk);
   endtask

   task automatic wait_sound(input logic lvl, input int budget, output int cyc);
      cyc = 0;
      while (o_sound !== lvl && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
      if (o_sound !== lvl) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_sound: alarm_sound still %b, wanted %b after %0d cycles", o_sound, lvl, cyc);
      end
   endtask

   initial begin
      logic err;
      int   cyc, t0, tr, k, d;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset display", {o_mh, o_lh, o_mm, o_lm}, 32'h30303030);
      check("reset sound", 32'(o_sound), 32'd0);
      check("reset active", 32'(o_active), 32'd0);

      // Set 11:23, then fastwatch advances one minute
      enter4(1123);
      check("entry display", {o_mh, o_lh, o_mm, o_lm}, 32'h31313233);
      load(1'b1, 1'b0, err);
      check("time display", {o_mh, o_lh, o_mm, o_lm}, 32'h31313233);
      fw = 1'b1;
      repeat (260) @(negedge clk);
      check("fastwatch minute", {o_mh, o_lh, o_mm, o_lm}, 32'h31313234);

      // Slot 0 = 11:30, time 11:23: ring after 7 minutes, self-clear after 10 seconds
      enter4(1130); sel = 2'd0; load(1'b0, 1'b1, err);
      enter4(1123); en = 4'b0001; load(1'b1, 1'b0, err);
      wait_sound(1'b1, 8 * CPS, cyc);
      check("ring latency", 32'(cyc), 32'(7 * CPS));
      check("ring active", 32'(o_active), 32'b0001);
      check("model ring time", 32'(m_min), 32'(11 * 60 + 30));
      wait_sound(1'b0, 11 * CPS, cyc);
      check("ring duration", 32'(cyc), 32'(TO * CPS - 1));
      check("timeout active", 32'(o_active), 32'd0);

      // Snooze at 11:30, re-ring at 11:35, then stop
      enter4(1129); load(1'b1, 1'b0, err);
      wait_sound(1'b1, 2 * CPS, cyc);
      snz = 1'b1; @(negedge clk); snz = 1'b0; @(negedge clk);
      check("snoozed sound", 32'(o_sound), 32'd0);
      check("snoozed active", 32'(o_active), 32'b0001);
      wait_sound(1'b1, 6 * CPS, cyc);
      check("model snooze time", 32'(m_min), 32'(11 * 60 + 35));
      check("re-ring active", 32'(o_active), 32'b0001);
      pulse_stop();
      fw = 1'b0;
      check("stopped sound", 32'(o_sound), 32'd0);

      // Invalid loads are rejected
      t0 = m_min;
      enter4(2400); load(1'b1, 1'b0, err);
      check("bad time err", 32'(err), 32'd1);
      check("bad time display", {o_mh, o_lh, o_mm, o_lm}, 32'h31313335);
      enter4(1260); sel = 2'd0; load(1'b0, 1'b1, err);
      check("bad alarm err", 32'(err), 32'd1);
      check("model slot kept", 32'(m_slot[0]), 32'(11 * 60 + 30));
      check("model time kept", 32'(m_min), 32'(t0));

      // Midnight wrap with two slots at 00:00
      en = 4'b0110;
      enter4(0); sel = 2'd1; load(1'b0, 1'b1, err);
      enter4(0); sel = 2'd2; load(1'b0, 1'b1, err);
      enter4(2359); load(1'b1, 1'b0, err);
      fw = 1'b1;
      wait_sound(1'b1, 2 * CPS, cyc);
      check("wrap display", {o_mh, o_lh, o_mm, o_lm}, 32'h30303030);
      check("wrap active", 32'(o_active), 32'b0110);
      pulse_stop();
      fw = 1'b0;

      // Both buttons: only the time loads
      enter4(805); sel = 2'd3; load(1'b1, 1'b1, err);
      check("both err", 32'(err), 32'd0);
      check("both display", {o_mh, o_lh, o_mm, o_lm}, 32'h30383035);
      check("model slot3 kept", 32'(m_slot[3]), 32'd0);

      // Async reset while ringing
      en = 4'b1000;
      enter4(806); sel = 2'd3; load(1'b0, 1'b1, err);
      fw = 1'b1;
      wait_sound(1'b1, 3 * CPS, cyc);
      check("pre-reset active", 32'(o_active), 32'b1000);
      rst = 1'b1;
      #1;
      check("async reset sound", 32'(o_sound), 32'd0);
      check("async reset display", {o_mh, o_lh, o_mm, o_lm}, 32'h30303030);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Random traffic around randomly placed alarms
      for (int it = 0; it < 6; it++) begin
         tr = $urandom_range(0, 1439);
         k  = $urandom_range(0, NA - 1);
         d  = $urandom_range(1, 3);
         fw = 1'b1;
         enter4(min_to_hhmm((tr + d) % 1440)); sel = 2'(k); load(1'b0, 1'b1, err);
         en = 4'($urandom_range(0, 15)) | 4'(1 << k);
         enter4(min_to_hhmm(tr)); load(1'b1, 1'b0, err);
         for (int c = 0; c < 1500; c++) begin
            snz       = ($urandom_range(0, 299) == 0);
            stp       = ($urandom_range(0, 599) == 0);
            time_btn  = ($urandom_range(0, 799) == 0);
            alarm_btn = ($urandom_range(0, 399) == 0);
            sel       = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) key = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 499) == 0) en = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 999) == 0) fw = ~fw;
            @(negedge clk);
         end
         snz = 1'b0; stp = 1'b0; time_btn = 1'b0; alarm_btn = 1'b0; key = 4'd15;
         @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
